// File: rtl/huffman_pkg.sv
// Shared constants, FSM state type and helpers for the Huffman decoder.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package huffman_pkg;

  localparam int NUM_SYM = 6;
  localparam int CODE_W  = 8;
  localparam int LEN_W   = 4;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_e;

  // Index 0 holds symbol 1, index NUM_SYM-1 holds symbol NUM_SYM.
  typedef logic [NUM_SYM-1:0][CODE_W-1:0] tbl_t;

  // Bitwise 2-of-3 majority vote.
  function automatic logic [CODE_W-1:0] maj3(input logic [CODE_W-1:0] a,
                                             input logic [CODE_W-1:0] b,
                                             input logic [CODE_W-1:0] c);
    return (a & b) | (a & c) | (b & c);
  endfunction

  // Number of set bits in a mask; this is the code length of a symbol.
  function automatic logic [LEN_W-1:0] popcnt(input logic [CODE_W-1:0] v);
    logic [LEN_W-1:0] n;
    n = '0;
    for (int k = 0; k < CODE_W; k++) n = n + LEN_W'(v[k]);
    return n;
  endfunction

endpackage

// File: rtl/huffman_decoder_if.sv
// Table-load, serial-bit and decoded-symbol signals of the Huffman decoder.
// Latency: n/a (wiring only).
// Backpressure: bit_valid/bit_ready in, gray_valid/gray_ready out.
interface huffman_decoder_if;
  import huffman_pkg::*;

  logic              code_valid;
  logic [CODE_W-1:0] HC1, HC2, HC3, HC4, HC5, HC6;
  logic [CODE_W-1:0] M1, M2, M3, M4, M5, M6;
  logic              bit_valid;
  logic              bit_in;
  logic              bit_ready;
  logic              gray_valid;
  logic [CODE_W-1:0] gray_data;
  logic              gray_ready;
  logic              dec_err;

  modport master (
    output code_valid, HC1, HC2, HC3, HC4, HC5, HC6, M1, M2, M3, M4, M5, M6,
    output bit_valid, bit_in, gray_ready,
    input  bit_ready, gray_valid, gray_data, dec_err
  );

  modport slave (
    input  code_valid, HC1, HC2, HC3, HC4, HC5, HC6, M1, M2, M3, M4, M5, M6,
    input  bit_valid, bit_in, gray_ready,
    output bit_ready, gray_valid, gray_data, dec_err
  );

endinterface

// File: rtl/huffman_dec_core.sv
// Serial Huffman decode core: shifts code bits in and matches them against a loaded table.
// Latency: symbol (or dec_err pulse) one cycle after the final bit is accepted.
// Backpressure: bit_ready drops while a decoded symbol is held unaccepted or a table loads.
module huffman_dec_core
  import huffman_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              code_valid,
  input  tbl_t              hc_tbl,
  input  tbl_t              m_tbl,
  input  logic              bit_valid,
  input  logic              bit_in,
  input  logic              gray_ready,
  output logic              bit_ready,
  output logic              gray_valid,
  output logic [CODE_W-1:0] gray_data,
  output logic              dec_err
);

  state_e            state_q, state_d;
  tbl_t              hc_q, hc_d, m_q, m_d;
  logic [CODE_W-1:0] sr_q, sr_d, sr_shift;
  logic [LEN_W-1:0]  len_q, len_d, len_inc;
  logic              gv_q, gv_d;
  logic [CODE_W-1:0] gd_q, gd_d;
  logic              err_q, err_d;
  logic              bit_xfer;
  logic              hit;
  logic [CODE_W-1:0] hit_idx;

  // A new bit may enter whenever no symbol is stuck at the sink; a table load takes the cycle.
  assign bit_ready  = (state_q == ST_RUN) && !(gv_q && !gray_ready) && !code_valid;
  assign bit_xfer   = bit_valid && bit_ready;
  assign gray_valid = gv_q;
  assign gray_data  = gd_q;
  assign dec_err    = err_q;

  // Next-state: table load, post-shift match with lowest-index priority, overflow error.
  always_comb begin
    state_d  = state_q;
    hc_d     = hc_q;
    m_d      = m_q;
    sr_d     = sr_q;
    len_d    = len_q;
    gv_d     = gv_q;
    gd_d     = gd_q;
    err_d    = 1'b0;
    sr_shift = {sr_q[CODE_W-2:0], bit_in};
    len_inc  = len_q + LEN_W'(1);
    hit      = 1'b0;
    hit_idx  = '0;
    // Scan downward so the lowest matching index is the one left standing.
    for (int i = NUM_SYM - 1; i >= 0; i--) begin
      if ((m_q[i] != '0) && (len_inc == popcnt(m_q[i])) &&
          ((sr_shift & m_q[i]) == (hc_q[i] & m_q[i]))) begin
        hit     = 1'b1;
        hit_idx = CODE_W'(i + 1);
      end
    end
    if (code_valid) begin
      state_d = ST_RUN;
      hc_d    = hc_tbl;
      m_d     = m_tbl;
      sr_d    = '0;
      len_d   = '0;
      gv_d    = 1'b0;
      gd_d    = '0;
    end else begin
      if (gv_q && gray_ready) gv_d = 1'b0;
      if (bit_xfer) begin
        if (hit) begin
          gv_d  = 1'b1;
          gd_d  = hit_idx;
          sr_d  = '0;
          len_d = '0;
        end else if (len_inc == LEN_W'(CODE_W)) begin
          err_d = 1'b1;
          sr_d  = '0;
          len_d = '0;
        end else begin
          sr_d  = sr_shift;
          len_d = len_inc;
        end
      end
    end
  end

  // State and output registers; reset wins over everything, including a table load.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      hc_q    <= '0;
      m_q     <= '0;
      sr_q    <= '0;
      len_q   <= '0;
      gv_q    <= 1'b0;
      gd_q    <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      hc_q    <= hc_d;
      m_q     <= m_d;
      sr_q    <= sr_d;
      len_q   <= len_d;
      gv_q    <= gv_d;
      gd_q    <= gd_d;
      err_q   <= err_d;
    end
  end

endmodule

// File: rtl/huffman_decoder.sv
// Huffman decoder wrapper; HUFFMAN_DEC_TMR_EN triplicates the core behind 2-of-3 voters.
// Latency: symbol one cycle after the final code bit, identical in both builds.
// Backpressure: bit_ready low while gray_valid is held against gray_ready=0 or a table loads.
module huffman_decoder
  import huffman_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  huffman_decoder_if.slave dif
);

  tbl_t hc_tbl, m_tbl;

  assign hc_tbl = {dif.HC6, dif.HC5, dif.HC4, dif.HC3, dif.HC2, dif.HC1};
  assign m_tbl  = {dif.M6, dif.M5, dif.M4, dif.M3, dif.M2, dif.M1};

`ifdef HUFFMAN_DEC_TMR_EN
  logic              br0, br1, br2, gv0, gv1, gv2, er0, er1, er2;
  logic [CODE_W-1:0] gd0, gd1, gd2;
  logic [CODE_W-1:0] ctl_v;

  huffman_dec_core u_core0 (
    .clk, .reset, .code_valid(dif.code_valid), .hc_tbl, .m_tbl,
    .bit_valid(dif.bit_valid), .bit_in(dif.bit_in), .gray_ready(dif.gray_ready),
    .bit_ready(br0), .gray_valid(gv0), .gray_data(gd0), .dec_err(er0)
  );
  huffman_dec_core u_core1 (
    .clk, .reset, .code_valid(dif.code_valid), .hc_tbl, .m_tbl,
    .bit_valid(dif.bit_valid), .bit_in(dif.bit_in), .gray_ready(dif.gray_ready),
    .bit_ready(br1), .gray_valid(gv1), .gray_data(gd1), .dec_err(er1)
  );
  huffman_dec_core u_core2 (
    .clk, .reset, .code_valid(dif.code_valid), .hc_tbl, .m_tbl,
    .bit_valid(dif.bit_valid), .bit_in(dif.bit_in), .gray_ready(dif.gray_ready),
    .bit_ready(br2), .gray_valid(gv2), .gray_data(gd2), .dec_err(er2)
  );

  // Control bits share one voter word: bit 2 ready, bit 1 valid, bit 0 error.
  assign ctl_v = maj3({5'b0, br0, gv0, er0}, {5'b0, br1, gv1, er1}, {5'b0, br2, gv2, er2});

  assign dif.bit_ready  = ctl_v[2];
  assign dif.gray_valid = ctl_v[1];
  assign dif.dec_err    = ctl_v[0];
  assign dif.gray_data  = maj3(gd0, gd1, gd2);
`else
  huffman_dec_core u_core (
    .clk, .reset, .code_valid(dif.code_valid), .hc_tbl, .m_tbl,
    .bit_valid(dif.bit_valid), .bit_in(dif.bit_in), .gray_ready(dif.gray_ready),
    .bit_ready(dif.bit_ready), .gray_valid(dif.gray_valid),
    .gray_data(dif.gray_data), .dec_err(dif.dec_err)
  );
`endif

endmodule

// File: tb/tb_huffman_decoder.sv
// Self-checking bench for huffman_decoder: vector table, directed corner sequences, random run.
// Latency: expects each symbol or error one cycle after its final bit.
// Backpressure: drives gray_ready low to hold symbols and stall the bit stream.
module tb_huffman_decoder;
  import huffman_pkg::*;

  logic clk;
  logic reset;
  huffman_decoder_if dif();

  huffman_decoder dut (.clk(clk), .reset(reset), .dif(dif));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, req);
    end
  endtask

  // ---------------- reference model: bit string + code table ----------------
  bit   mon_en = 1'b0;
  bit   m_run = 1'b0;
  int   m_hc[6];
  int   m_m[6];
  int   m_v = 0;
  int   m_n = 0;
  bit   exp_gv = 1'b0;
  int   exp_gd = 0;
  bit   exp_err = 1'b0;
  bit   exp_br;
  bit   found;
  int   got[$];

  always @(negedge clk) begin
    if (mon_en) begin
      exp_br = m_run && !(exp_gv && !dif.gray_ready) && !dif.code_valid;
      chk("mon_bit_ready", dif.bit_ready, exp_br);
      chk("mon_gray_valid", dif.gray_valid, exp_gv);
      if (exp_gv) chk("mon_gray_data", dif.gray_data, exp_gd);
      chk("mon_dec_err", dif.dec_err, exp_err);
      if (dif.gray_valid && dif.gray_ready) got.push_back(int'(dif.gray_data));
      if (reset) begin
        m_run = 0; m_v = 0; m_n = 0; exp_gv = 0; exp_gd = 0; exp_err = 0;
      end else if (dif.code_valid) begin
        m_run = 1; m_v = 0; m_n = 0; exp_gv = 0; exp_err = 0;
        m_hc = '{int'(dif.HC1), int'(dif.HC2), int'(dif.HC3), int'(dif.HC4), int'(dif.HC5), int'(dif.HC6)};
        m_m  = '{int'(dif.M1), int'(dif.M2), int'(dif.M3), int'(dif.M4), int'(dif.M5), int'(dif.M6)};
      end else begin
        exp_err = 0;
        if (exp_gv && dif.gray_ready) exp_gv = 0;
        if (exp_br && dif.bit_valid) begin
          m_v = (m_v * 2 + int'(dif.bit_in)) % 256;
          m_n = m_n + 1;
          found = 0;
          for (int k = 0; k < 6; k++) begin
            if (!found && m_m[k] != 0 && m_n == $countones(m_m[k]) &&
                ((m_v & m_m[k]) == (m_hc[k] & m_m[k]))) begin
              found = 1; exp_gv = 1; exp_gd = k + 1;
            end
          end
          if (found || m_n == 8) begin
            if (!found) exp_err = 1;
            m_v = 0; m_n = 0;
          end
        end
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  int stalls = 0;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load_table(input tbl_t hc, input tbl_t m);
    dif.code_valid = 1'b1;
    dif.HC1 = hc[0]; dif.HC2 = hc[1]; dif.HC3 = hc[2];
    dif.HC4 = hc[3]; dif.HC5 = hc[4]; dif.HC6 = hc[5];
    dif.M1 = m[0]; dif.M2 = m[1]; dif.M3 = m[2];
    dif.M4 = m[3]; dif.M5 = m[4]; dif.M6 = m[5];
    tick();
    dif.code_valid = 1'b0;
  endtask

  task automatic send_bit(input logic b);
    logic ok;
    ok = 1'b0;
    dif.bit_valid = 1'b1;
    dif.bit_in = b;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      ok = dif.bit_ready;
      tick();
      if (ok) break;
      stalls++;
    end
    dif.bit_valid = 1'b0;
    chk("send_bit_accepted", ok, 1'b1);
  endtask

  typedef struct {
    int         tbl;
    logic [7:0] bits;
    int         nbits;
    int         sym;
    logic       err;
  } vec_t;

  tbl_t tb_hc[4];
  tbl_t tb_m[4];
  vec_t vecs[10];
  vec_t v;
  tbl_t rhc, rm;
  int   exp_seq[8];
  logic [7:0] s8;

  initial begin
    // Table 0: prefix code 0,10,110,1110,11110,11111.
    tb_hc[0] = {8'd31, 8'd30, 8'd14, 8'd6, 8'd2, 8'd0};
    tb_m[0]  = {8'd31, 8'd31, 8'd15, 8'd7, 8'd3, 8'd1};
    // Table 1: one-bit codes only.
    tb_hc[1] = {8'd0, 8'd0, 8'd0, 8'd0, 8'd1, 8'd0};
    tb_m[1]  = {8'd0, 8'd0, 8'd0, 8'd0, 8'd1, 8'd1};
    // Table 2: empty.
    tb_hc[2] = '0;
    tb_m[2]  = '0;
    // Table 3: malformed, symbols 1 and 2 share code 10.
    tb_hc[3] = {8'd0, 8'd0, 8'd0, 8'd0, 8'd2, 8'd2};
    tb_m[3]  = {8'd0, 8'd0, 8'd0, 8'd0, 8'd3, 8'd3};

    vecs[0] = '{0, 8'b0,        1, 1, 1'b0};
    vecs[1] = '{0, 8'b10,       2, 2, 1'b0};
    vecs[2] = '{0, 8'b110,      3, 3, 1'b0};
    vecs[3] = '{0, 8'b1110,     4, 4, 1'b0};
    vecs[4] = '{0, 8'b11110,    5, 5, 1'b0};
    vecs[5] = '{0, 8'b11111,    5, 6, 1'b0};
    vecs[6] = '{1, 8'b0,        1, 1, 1'b0};
    vecs[7] = '{1, 8'b1,        1, 2, 1'b0};
    vecs[8] = '{2, 8'b10110011, 8, 0, 1'b1};
    vecs[9] = '{3, 8'b10,       2, 1, 1'b0};

    reset = 1'b1;
    dif.code_valid = 1'b0; dif.bit_valid = 1'b0; dif.bit_in = 1'b0; dif.gray_ready = 1'b0;
    dif.HC1 = '0; dif.HC2 = '0; dif.HC3 = '0; dif.HC4 = '0; dif.HC5 = '0; dif.HC6 = '0;
    dif.M1 = '0; dif.M2 = '0; dif.M3 = '0; dif.M4 = '0; dif.M5 = '0; dif.M6 = '0;
    tick();
    tick();
    mon_en = 1'b1;
    @(negedge clk);
    chk("rst_bit_ready", dif.bit_ready, 1'b0);
    chk("rst_gray_valid", dif.gray_valid, 1'b0);
    chk("rst_gray_data", dif.gray_data, 8'd0);
    chk("rst_dec_err", dif.dec_err, 1'b0);
    tick();
    reset = 1'b0;

    // Bits offered before any table are ignored.
    dif.bit_valid = 1'b1; dif.bit_in = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("idle_bit_ready", dif.bit_ready, 1'b0);
      chk("idle_gray_valid", dif.gray_valid, 1'b0);
      tick();
    end
    dif.bit_valid = 1'b0;

    // ---- vector table ----
    dif.gray_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      v = vecs[i];
      load_table(tb_hc[v.tbl], tb_m[v.tbl]);
      for (int b = v.nbits - 1; b >= 0; b--) send_bit(v.bits[b]);
      @(negedge clk);
      chk($sformatf("vec%0d_gray_valid", i), dif.gray_valid, !v.err);
      chk($sformatf("vec%0d_dec_err", i), dif.dec_err, v.err);
      if (!v.err) chk($sformatf("vec%0d_gray_data", i), dif.gray_data, v.sym);
      tick();
      if (v.err) begin
        @(negedge clk);
        chk($sformatf("vec%0d_err_one_cycle", i), dif.dec_err, 1'b0);
        tick();
      end
    end

    // ---- back-to-back stream 0,1,0,1,1,1,1,1 -> 1,2,6 ----
    load_table(tb_hc[0], tb_m[0]);
    got.delete();
    stalls = 0;
    s8 = 8'b01011111;
    for (int b = 7; b >= 0; b--) send_bit(s8[b]);
    tick();
    tick();
    chk("b2b_no_stall", stalls, 0);
    chk("b2b_count", got.size(), 3);
    if (got.size() == 3) begin
      chk("b2b_sym0", got[0], 1);
      chk("b2b_sym1", got[1], 2);
      chk("b2b_sym2", got[2], 6);
    end

    // ---- one-bit table over 8 bits of table-0 prefix, then empty table ----
    load_table(tb_hc[1], tb_m[1]);
    got.delete();
    s8 = 8'b11110100;
    exp_seq = '{2, 2, 2, 2, 1, 2, 1, 1};
    for (int b = 7; b >= 0; b--) send_bit(s8[b]);
    tick();
    tick();
    chk("onebit_count", got.size(), 8);
    if (got.size() == 8)
      for (int k = 0; k < 8; k++) chk($sformatf("onebit_sym%0d", k), got[k], exp_seq[k]);
    load_table(tb_hc[2], tb_m[2]);
    for (int b = 7; b >= 0; b--) send_bit(s8[b]);
    @(negedge clk);
    chk("empty_dec_err", dif.dec_err, 1'b1);
    chk("empty_gray_valid", dif.gray_valid, 1'b0);
    tick();

    // ---- hold: sink stalls five cycles after symbol 3 ----
    load_table(tb_hc[0], tb_m[0]);
    dif.gray_ready = 1'b0;
    send_bit(1'b1); send_bit(1'b1); send_bit(1'b0);
    dif.bit_valid = 1'b1; dif.bit_in = 1'b0;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk("hold_bit_ready", dif.bit_ready, 1'b0);
      chk("hold_gray_valid", dif.gray_valid, 1'b1);
      chk("hold_gray_data", dif.gray_data, 8'd3);
      tick();
    end
    dif.gray_ready = 1'b1;
    @(negedge clk);
    chk("release_bit_ready", dif.bit_ready, 1'b1);
    tick();
    dif.bit_valid = 1'b0;
    @(negedge clk);
    chk("release_gray_valid", dif.gray_valid, 1'b1);
    chk("release_gray_data", dif.gray_data, 8'd1);
    tick();

    // ---- reset after two of four bits ----
    load_table(tb_hc[0], tb_m[0]);
    send_bit(1'b0);
    send_bit(1'b1); send_bit(1'b1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    @(negedge clk);
    chk("midrst_bit_ready", dif.bit_ready, 1'b0);
    chk("midrst_gray_valid", dif.gray_valid, 1'b0);
    chk("midrst_gray_data", dif.gray_data, 8'd0);
    chk("midrst_dec_err", dif.dec_err, 1'b0);
    tick();
    dif.bit_valid = 1'b1; dif.bit_in = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("midrst_idle_ready", dif.bit_ready, 1'b0);
      tick();
    end
    dif.bit_valid = 1'b0;
    load_table(tb_hc[0], tb_m[0]);
    send_bit(1'b1); send_bit(1'b1); send_bit(1'b1); send_bit(1'b0);
    @(negedge clk);
    chk("postrst_gray_data", dif.gray_data, 8'd4);
    tick();

`ifdef HUFFMAN_DEC_TMR_EN
    // ---- one corrupted core is outvoted ----
    load_table(tb_hc[0], tb_m[0]);
    force dut.gd1 = 8'hFF;
    send_bit(1'b1); send_bit(1'b1); send_bit(1'b0);
    @(negedge clk);
    chk("tmr_gray_valid", dif.gray_valid, 1'b1);
    chk("tmr_gray_data", dif.gray_data, 8'd3);
    tick();
    release dut.gd1;
`endif

    // ---- random run against the model ----
    load_table(tb_hc[0], tb_m[0]);
    for (int c = 0; c < 4000; c++) begin
      if (c % 500 == 250) begin
        if ($urandom_range(0, 1) == 0) begin
          rhc = tb_hc[0]; rm = tb_m[0];
        end else begin
          for (int k = 0; k < 6; k++) begin
            rm[k]  = 8'((1 << $urandom_range(0, 8)) - 1);
            rhc[k] = 8'($urandom) & rm[k];
          end
        end
        dif.bit_valid = 1'b0;
        load_table(rhc, rm);
      end else if (c % 1300 == 1299) begin
        reset = 1'b1;
        tick();
        reset = 1'b0;
        load_table(tb_hc[0], tb_m[0]);
      end else begin
        dif.bit_valid  = ($urandom_range(0, 3) != 0);
        dif.bit_in     = 1'($urandom);
        dif.gray_ready = ($urandom_range(0, 2) != 0);
        tick();
      end
    end
    dif.bit_valid = 1'b0;
    dif.gray_ready = 1'b1;
    tick();
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
